nanov_spi_ram_responder: RTL

// - SPI memory responder (target side) of the instruction/data SPI bus driven by the nanoV CPU.
// - Decodes standard SPI RAM READ (0x03) and WRITE (0x02) commands with a 24-bit address.
// - Serves them from an internal byte array; used as on-chip/sim memory behind the CPU's SPI master.
// - Fully synchronous to the CPU clock: the master's clock enable qualifies every bit.

---
 rtl/nanov_spi_ram_responder_if.sv | 22 ++
 rtl/nanov_spi_ram_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_ram_responder_if.sv
// SPI link between the nanoV SPI master and the RAM responder; the master drives select/strobe/mosi.
// Responder returns registered miso; there is no backpressure, every qualified strobe moves one bit.
interface nanov_spi_ram_responder_if;
   logic spi_select;
   logic spi_clk_enable;
   logic spi_mosi;
   logic spi_miso;

   modport master (
      output spi_select,
      output spi_clk_enable,
      output spi_mosi,
      input  spi_miso
   );

   modport slave (
      input  spi_select,
      input  spi_clk_enable,
      input  spi_mosi,
      output spi_miso
   );
endinterface

// File: rtl/nanov_spi_ram_responder.sv
// SPI RAM target for nanoV: READ 0x03 / WRITE 0x02, 24-bit address, miso registered one clk after each strobe.
// No backpressure (master paces via spi_clk_enable); NANOV_SPI_RAM_FAST_READ_EN adds FAST READ 0x0B.
module nanov_spi_ram_responder #(
   parameter int ADDR_BITS = 10,
   parameter     INIT_FILE = ""
) (
   input  logic                        clk,
   input  logic                        rstn,
   nanov_spi_ram_responder_if.slave    spi,
   input  logic                        load_en,
   input  logic [ADDR_BITS-1:0]        load_addr,
   input  logic [7:0]                  load_data,
   output logic                        busy,
   output logic                        cmd_error
);

   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
`ifdef NANOV_SPI_RAM_FAST_READ_EN
      S_DUMMY,
`endif
      S_RD,
      S_WR,
      S_IGNORE
   } state_t;

   state_t                 state_q, state_n;
   logic [4:0]             bit_cnt_q, bit_cnt_n;
   logic [ADDR_BITS-1:0]   addr_q, addr_n;
   logic [7:0]             rx_sr_q, rx_sr_n;
   logic [7:0]             tx_sr_q, tx_sr_n;
   logic                   miso_q, miso_n;
   logic                   err_q, err_n;
   logic                   strobe;
   logic                   mem_we;
   logic [7:0]             mem_wdata;
   logic [7:0]             mem [0:(1<<ADDR_BITS)-1];

   assign strobe    = !spi.spi_select && spi.spi_clk_enable;
   assign mem_wdata = {rx_sr_q[6:0], spi.spi_mosi};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         addr_q    <= '0;
         rx_sr_q   <= '0;
         tx_sr_q   <= '0;
         miso_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         bit_cnt_q <= bit_cnt_n;
         addr_q    <= addr_n;
         rx_sr_q   <= rx_sr_n;
         tx_sr_q   <= tx_sr_n;
         miso_q    <= miso_n;
         err_q     <= err_n;
      end
   end

   // rx_sr keeps the opcode through ADDR so the end of the address can pick RD/WR/DUMMY.
   always_comb begin
      state_n   = state_q;
      bit_cnt_n = bit_cnt_q;
      addr_n    = addr_q;
      rx_sr_n   = rx_sr_q;
      tx_sr_n   = tx_sr_q;
      miso_n    = miso_q;
      err_n     = err_q;
      mem_we    = 1'b0;
      if (spi.spi_select) begin
         state_n   = S_IDLE;
         bit_cnt_n = '0;
         miso_n    = 1'b0;
      end else if (strobe) begin
         case (state_q)
            S_IDLE: begin
               rx_sr_n   = {rx_sr_q[6:0], spi.spi_mosi};
               bit_cnt_n = 5'd1;
               state_n   = S_CMD;
            end
            S_CMD: begin
               rx_sr_n = {rx_sr_q[6:0], spi.spi_mosi};
               if (bit_cnt_q == 5'd7) begin
                  bit_cnt_n = '0;
                  case (rx_sr_n)
                     8'h02, 8'h03: state_n = S_ADDR;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
                     8'h0B:        state_n = S_ADDR;
`endif
                     default: begin
                        state_n = S_IGNORE;
                        err_n   = 1'b1;
                     end
                  endcase
               end else begin
                  bit_cnt_n = bit_cnt_q + 5'd1;
               end
            end
            S_ADDR: begin
               addr_n = {addr_q[ADDR_BITS-2:0], spi.spi_mosi};
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_n = '0;
                  if (rx_sr_q == 8'h02) begin
                     state_n = S_WR;
`ifdef NANOV_SPI_RAM_FAST_READ_EN
                  end else if (rx_sr_q == 8'h0B) begin
                     state_n = S_DUMMY;
`endif
                  end else begin
                     state_n = S_RD;
                     tx_sr_n = mem[addr_n];
                     miso_n  = mem[addr_n][7];
                  end
               end else begin
                  bit_cnt_n = bit_cnt_q + 5'd1;
               end
            end
`ifdef NANOV_SPI_RAM_FAST_READ_EN
            S_DUMMY: begin
               miso_n = 1'b0;
               if (bit_cnt_q == 5'd7) begin
                  bit_cnt_n = '0;
                  state_n   = S_RD;
                  tx_sr_n   = mem[addr_q];
                  miso_n    = mem[addr_q][7];
               end else begin
                  bit_cnt_n = bit_cnt_q + 5'd1;
               end
            end
`endif
            S_RD: begin
               if (bit_cnt_q == 5'd7) begin
                  bit_cnt_n = '0;
                  addr_n    = addr_q + ADDR_ONE;
                  tx_sr_n   = mem[addr_n];
                  miso_n    = mem[addr_n][7];
               end else begin
                  bit_cnt_n = bit_cnt_q + 5'd1;
                  tx_sr_n   = {tx_sr_q[6:0], 1'b0};
                  miso_n    = tx_sr_q[6];
               end
            end
            S_WR: begin
               rx_sr_n = {rx_sr_q[6:0], spi.spi_mosi};
               if (bit_cnt_q == 5'd7) begin
                  bit_cnt_n = '0;
                  mem_we    = 1'b1;
                  addr_n    = addr_q + ADDR_ONE;
               end else begin
                  bit_cnt_n = bit_cnt_q + 5'd1;
               end
            end
            S_IGNORE: begin
               miso_n = 1'b0;
            end
            default: begin
               state_n   = S_IDLE;
               bit_cnt_n = '0;
               miso_n    = 1'b0;
            end
         endcase
      end
   end

   // SPI commit is written second so it wins over a backdoor load to the same byte.
   always_ff @(posedge clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
      if (mem_we)
         mem[addr_q] <= mem_wdata;
   end

   assign spi.spi_miso = miso_q;
   assign busy         = (state_q != S_IDLE);
   assign cmd_error    = err_q;

endmodule
